// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU VRAM arbiter: host FSM encoding,
// RAM geometry and starvation counter sizing.
package gpu_pkg;

  localparam int VRAM_ADDR_W = 14;
  localparam int VRAM_DATA_W = 32;

  localparam int STARVE_MAX = 255;
  localparam int STARVE_W   = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_SLOT = 2'd1,
    H_DATA = 2'd2,
    H_ACK  = 2'd3
  } host_st_e;

endpackage

// File: rtl/gpu_rd_pipe.sv
// Valid delay line with a data capture stage at its tail; carries
// render read results from the RAM slot back to the engine.
module gpu_rd_pipe #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         vld_i,
  input  logic [W-1:0] dat_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;
  logic             vld_q;
  logic [W-1:0]     dat_q;
  logic [W-1:0]     dat_d;

  always_comb begin
    sr_d  = (sr_q << 1) | DEPTH'(vld_i);
    dat_d = dat_q;
    if (sr_q[DEPTH-1]) dat_d = dat_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      sr_q  <= sr_d;
      vld_q <= sr_q[DEPTH-1];
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/gpu_vram_arbiter.sv
// Single-port VRAM arbiter: pipelined render reads with priority,
// Wishbone host uploads protected by a starvation counter.
module gpu_vram_arbiter
  import gpu_pkg::*;
#(
  parameter int ADDR_W       = VRAM_ADDR_W,
  parameter int DATA_W       = VRAM_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rnd_req_i,
  input  logic [ADDR_W-1:0] rnd_adr_i,
  output logic              rnd_gnt_o,
  output logic              rnd_valid_o,
  output logic [DATA_W-1:0] rnd_dat_o,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [31:0]       adr_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic [DATA_W-1:0] dat_o,
  output logic              ack_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_adr_o,
  output logic [DATA_W-1:0] ram_wdat_o,
  input  logic [DATA_W-1:0] ram_rdat_i
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  host_st_e            hst_q, hst_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                h_we_q, h_we_d;
  logic [DATA_W-1:0]   dat_q, dat_d;

  logic                ram_en_q, ram_en_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_adr_q, ram_adr_d;
  logic [DATA_W-1:0]   ram_wdat_q, ram_wdat_d;

  logic host_pend;
  logic starve_hit;
  logic host_win;
  logic rnd_win;
  logic unused_adr;

  assign unused_adr = ^{adr_i[31:ADDR_W+2], adr_i[1:0]};

  always_comb begin
    host_pend  = cyc_i & stb_i & (hst_q == H_IDLE);
    starve_hit = (starve_q == LIMIT);
    host_win   = host_pend & (~rnd_req_i | starve_hit);
    rnd_win    = rnd_req_i & ~host_win;

    starve_d = starve_q;
    if (!host_pend || host_win) starve_d = '0;
    else if (rnd_win && !starve_hit) starve_d = starve_q + 1'b1;
  end

  assign rnd_gnt_o = rnd_win & rst_n;

  // Each grant owns the RAM slot of the following cycle.
  always_comb begin
    ram_en_d   = host_win | rnd_win;
    ram_we_d   = host_win & we_i;
    ram_adr_d  = '0;
    ram_wdat_d = '0;
    if (host_win) begin
      ram_adr_d = adr_i[ADDR_W+1:2];
      if (we_i) ram_wdat_d = dat_i;
    end else if (rnd_win) begin
      ram_adr_d = rnd_adr_i;
    end
  end

  always_comb begin
    hst_d  = hst_q;
    h_we_d = h_we_q;
    dat_d  = dat_q;
    unique case (hst_q)
      H_IDLE: begin
        if (host_win) begin
          hst_d  = H_SLOT;
          h_we_d = we_i;
        end
      end
      H_SLOT: hst_d = H_DATA;
      H_DATA: begin
        hst_d = H_ACK;
        if (!h_we_q) dat_d = ram_rdat_i;
      end
      H_ACK:  hst_d = H_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hst_q      <= H_IDLE;
      starve_q   <= '0;
      h_we_q     <= 1'b0;
      dat_q      <= '0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_adr_q  <= '0;
      ram_wdat_q <= '0;
    end else begin
      hst_q      <= hst_d;
      starve_q   <= starve_d;
      h_we_q     <= h_we_d;
      dat_q      <= dat_d;
      ram_en_q   <= ram_en_d;
      ram_we_q   <= ram_we_d;
      ram_adr_q  <= ram_adr_d;
      ram_wdat_q <= ram_wdat_d;
    end
  end

  // A dropped cycle suppresses the ack; the write already happened.
  assign ack_o      = (hst_q == H_ACK) & cyc_i;
  assign dat_o      = dat_q;
  assign ram_en_o   = ram_en_q;
  assign ram_we_o   = ram_we_q;
  assign ram_adr_o  = ram_adr_q;
  assign ram_wdat_o = ram_wdat_q;

  gpu_rd_pipe #(
    .DEPTH(2),
    .W    (DATA_W)
  ) u_rd_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .vld_i(rnd_win),
    .dat_i(ram_rdat_i),
    .vld_o(rnd_valid_o),
    .dat_o(rnd_dat_o)
  );

endmodule

// File: tb/tb_gpu_vram_arbiter.sv
// Self-checking bench for gpu_vram_arbiter: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_gpu_vram_arbiter;

  localparam int AW  = 14;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rnd_req_i = 1'b0;
  logic [AW-1:0] rnd_adr_i = '0;
  logic          rnd_gnt_o;
  logic          rnd_valid_o;
  logic [31:0]   rnd_dat_o;
  logic          cyc_i = 1'b0;
  logic          stb_i = 1'b0;
  logic          we_i = 1'b0;
  logic [31:0]   adr_i = '0;
  logic [31:0]   dat_i = '0;
  logic [31:0]   dat_o;
  logic          ack_o;
  logic          ram_en_o;
  logic          ram_we_o;
  logic [AW-1:0] ram_adr_o;
  logic [31:0]   ram_wdat_o;
  logic [31:0]   ram_rdat = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:(1<<AW)-1];
  logic        preload = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'(i * 3);
    end else if (ram_en_o) begin
      if (ram_we_o) mem[ram_adr_o] <= ram_wdat_o;
      else ram_rdat <= mem[ram_adr_o];
    end
  end

  gpu_vram_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (32),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rnd_req_i  (rnd_req_i),
    .rnd_adr_i  (rnd_adr_i),
    .rnd_gnt_o  (rnd_gnt_o),
    .rnd_valid_o(rnd_valid_o),
    .rnd_dat_o  (rnd_dat_o),
    .cyc_i      (cyc_i),
    .stb_i      (stb_i),
    .we_i       (we_i),
    .adr_i      (adr_i),
    .dat_i      (dat_i),
    .dat_o      (dat_o),
    .ack_o      (ack_o),
    .ram_en_o   (ram_en_o),
    .ram_we_o   (ram_we_o),
    .ram_adr_o  (ram_adr_o),
    .ram_wdat_o (ram_wdat_o),
    .ram_rdat_i (ram_rdat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rnd_req_i = 1'b1;
    cyc_i = 1'b1;
    stb_i = 1'b1;
    #3;
    checks++;
    if ({rnd_gnt_o, rnd_valid_o, ack_o, ram_en_o, ram_we_o} !== 5'b0 ||
        rnd_dat_o !== 32'h0 || dat_o !== 32'h0 ||
        ram_adr_o !== '0 || ram_wdat_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b v=%b ack=%b en=%b we=%b rd=%h do=%h ra=%h wd=%h exp all 0",
               rnd_gnt_o, rnd_valid_o, ack_o, ram_en_o, ram_we_o,
               rnd_dat_o, dat_o, ram_adr_o, ram_wdat_o);
    end
    preload = 1'b1;
    tick();
    preload = 1'b0;
    rnd_req_i = 1'b0;
    cyc_i = 1'b0;
    stb_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_render_burst();
    for (int i = 0; i < 14; i++) begin
      rnd_req_i = (i < 8);
      rnd_adr_i = AW'(i < 8 ? i : 0);
      #3;
      checks++;
      if (rnd_gnt_o !== (i < 8)) begin
        errors++;
        $display("FAIL burst_gnt cyc %0d got %b exp %b", i, rnd_gnt_o, i < 8);
      end
      checks++;
      if (rnd_valid_o !== (i >= 3 && i < 11)) begin
        errors++;
        $display("FAIL burst_valid cyc %0d got %b exp %b", i, rnd_valid_o, i >= 3 && i < 11);
      end
      if (i >= 3 && i < 11) begin
        checks++;
        if (rnd_dat_o !== 32'((i - 3) * 3)) begin
          errors++;
          $display("FAIL burst_data cyc %0d got %h exp %h", i, rnd_dat_o, 32'((i - 3) * 3));
        end
      end
      tick();
    end
  endtask

  task automatic test_host_write();
    for (int i = 0; i < 5; i++) begin
      cyc_i = (i < 4);
      stb_i = (i < 4);
      we_i  = (i < 4);
      adr_i = 32'h10;
      dat_i = 32'hDEADBEEF;
      #3;
      checks++;
      if (ack_o !== (i == 3)) begin
        errors++;
        $display("FAIL wr_ack cyc %0d got %b exp %b", i, ack_o, i == 3);
      end
      if (i == 1) begin
        checks++;
        if ({ram_en_o, ram_we_o} !== 2'b11 || ram_adr_o !== AW'(4) ||
            ram_wdat_o !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL wr_slot got en=%b we=%b adr=%h wd=%h exp 1 1 4 deadbeef",
                   ram_en_o, ram_we_o, ram_adr_o, ram_wdat_o);
        end
      end
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      cyc_i = (i < 4);
      stb_i = (i < 4);
      we_i  = 1'b0;
      dat_i = 32'h0;
      #3;
      if (i == 1) begin
        checks++;
        if ({ram_en_o, ram_we_o} !== 2'b10 || ram_adr_o !== AW'(4)) begin
          errors++;
          $display("FAIL rd_slot got en=%b we=%b adr=%h exp 1 0 4", ram_en_o, ram_we_o, ram_adr_o);
        end
      end
      if (i == 3) begin
        checks++;
        if (ack_o !== 1'b1 || dat_o !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL rd_back got ack=%b dat=%h exp 1 deadbeef", ack_o, dat_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_starvation();
    for (int i = 0; i < 9; i++) begin
      rnd_req_i = (i < 8);
      rnd_adr_i = AW'($urandom_range(0, 31));
      cyc_i = (i < 8);
      stb_i = (i < 8);
      we_i  = 1'b0;
      adr_i = 32'h10;
      #3;
      checks++;
      if (rnd_gnt_o !== (i < 8 && i != 4)) begin
        errors++;
        $display("FAIL starve_gnt cyc %0d got %b exp %b", i, rnd_gnt_o, i < 8 && i != 4);
      end
      checks++;
      if (ack_o !== (i == 7)) begin
        errors++;
        $display("FAIL starve_ack cyc %0d got %b exp %b", i, ack_o, i == 7);
      end
      if (i == 5) begin
        checks++;
        if ({ram_en_o, ram_we_o} !== 2'b10 || ram_adr_o !== AW'(4)) begin
          errors++;
          $display("FAIL starve_slot got en=%b we=%b adr=%h exp 1 0 4", ram_en_o, ram_we_o, ram_adr_o);
        end
      end
      if (i == 7) begin
        checks++;
        if (dat_o !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL starve_data got %h exp deadbeef", dat_o);
        end
      end
      tick();
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_stb_hold();
    for (int i = 0; i < 10; i++) begin
      cyc_i = (i < 8);
      stb_i = (i < 8);
      we_i  = 1'b0;
      adr_i = 32'h14;
      #3;
      checks++;
      if (ram_en_o !== (i == 1 || i == 5)) begin
        errors++;
        $display("FAIL hold_ram_en cyc %0d got %b exp %b", i, ram_en_o, i == 1 || i == 5);
      end
      checks++;
      if (ack_o !== (i == 3 || i == 7)) begin
        errors++;
        $display("FAIL hold_ack cyc %0d got %b exp %b", i, ack_o, i == 3 || i == 7);
      end
      if (i == 3 || i == 7) begin
        checks++;
        if (dat_o !== 32'd15) begin
          errors++;
          $display("FAIL hold_data cyc %0d got %h exp %h", i, dat_o, 32'd15);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      rnd_req_i = (i != 1);
      rnd_adr_i = AW'(i + 1);
      cyc_i = (i == 1);
      stb_i = (i == 1);
      we_i  = 1'b0;
      adr_i = 32'h18;
      tick();
    end
    rnd_req_i = 1'b1;
    cyc_i = 1'b1;
    stb_i = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rnd_gnt_o, rnd_valid_o, ack_o, ram_en_o, ram_we_o} !== 5'b0 ||
        rnd_dat_o !== 32'h0 || dat_o !== 32'h0 ||
        ram_adr_o !== '0 || ram_wdat_o !== 32'h0) begin
      errors++;
      $display("FAIL midrst_outputs got gnt=%b v=%b ack=%b en=%b we=%b rd=%h do=%h ra=%h wd=%h exp all 0",
               rnd_gnt_o, rnd_valid_o, ack_o, ram_en_o, ram_we_o,
               rnd_dat_o, dat_o, ram_adr_o, ram_wdat_o);
    end
    rnd_req_i = 1'b0;
    cyc_i = 1'b0;
    stb_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #3;
      checks++;
      if (rnd_valid_o !== 1'b0 || ack_o !== 1'b0) begin
        errors++;
        $display("FAIL midrst_quiet cyc %0d got v=%b ack=%b exp 0 0", i, rnd_valid_o, ack_o);
      end
      tick();
    end
    for (int i = 0; i < 7; i++) begin
      rnd_req_i = (i == 0);
      rnd_adr_i = AW'(7);
      cyc_i = (i >= 1 && i <= 4);
      stb_i = (i >= 1 && i <= 4);
      adr_i = 32'h18;
      #3;
      checks++;
      if (rnd_valid_o !== (i == 3) || ack_o !== (i == 4)) begin
        errors++;
        $display("FAIL midrst_resume cyc %0d got v=%b ack=%b exp %b %b",
                 i, rnd_valid_o, ack_o, i == 3, i == 4);
      end
      if (i == 3) begin
        checks++;
        if (rnd_dat_o !== 32'd21) begin
          errors++;
          $display("FAIL midrst_rnd_data got %h exp %h", rnd_dat_o, 32'd21);
        end
      end
      if (i == 4) begin
        checks++;
        if (dat_o !== 32'd18) begin
          errors++;
          $display("FAIL midrst_host_data got %h exp %h", dat_o, 32'd18);
        end
      end
      tick();
    end
  endtask

  task automatic test_cyc_drop();
    for (int i = 0; i < 6; i++) begin
      cyc_i = (i < 2);
      stb_i = (i < 2);
      we_i  = (i < 2);
      adr_i = 32'h20;
      dat_i = 32'hA5A50F0F;
      #3;
      checks++;
      if (ack_o !== 1'b0) begin
        errors++;
        $display("FAIL drop_ack cyc %0d got %b exp 0", i, ack_o);
      end
      tick();
    end
    checks++;
    if (mem[8] !== 32'hA5A50F0F) begin
      errors++;
      $display("FAIL drop_ram got %h exp a5a50f0f", mem[8]);
    end
    for (int i = 0; i < 5; i++) begin
      cyc_i = (i < 4);
      stb_i = (i < 4);
      we_i  = 1'b0;
      #3;
      if (i == 3) begin
        checks++;
        if (ack_o !== 1'b1 || dat_o !== 32'hA5A50F0F) begin
          errors++;
          $display("FAIL drop_readback got ack=%b dat=%h exp 1 a5a50f0f", ack_o, dat_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [0:31];
    int          qdue[$];
    logic [31:0] qdat[$];
    bit          hact;
    bit          hwe;
    int          hw;
    logic [31:0] hdat;
    logic [31:0] exp_rd;
    int          free_at;
    int          ack_due;
    int          starve;
    bit          pend;
    bit          hwin;
    bit          rwin;
    bit          expv;

    preload = 1'b1;
    tick();
    preload = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'(i * 3);
    hact = 0;
    hwe = 0;
    hw = 0;
    hdat = '0;
    exp_rd = '0;
    free_at = 0;
    ack_due = -1;
    starve = 0;

    for (int n = 0; n < 620; n++) begin
      if (!hact) begin
        cyc_i = 1'b0;
        stb_i = 1'b0;
        we_i  = 1'b0;
        if (n < 600 && $urandom_range(0, 2) == 0) begin
          hact = 1;
          hwe  = 1'($urandom_range(0, 1));
          hw   = $urandom_range(0, 31);
          hdat = $urandom;
          cyc_i = 1'b1;
          stb_i = 1'b1;
          we_i  = hwe;
          dat_i = hdat;
          adr_i = $urandom;
          adr_i[AW+1:2] = AW'(hw);
        end
      end
      rnd_req_i = (n < 600) && ($urandom_range(0, 3) != 0);
      rnd_adr_i = AW'($urandom_range(0, 31));
      #3;

      pend = hact && (n >= free_at);
      hwin = pend && (!rnd_req_i || starve == LIM);
      rwin = rnd_req_i && !hwin;
      if (!pend || hwin) starve = 0;
      else if (starve < LIM) starve++;

      checks++;
      if (rnd_gnt_o !== rwin) begin
        errors++;
        $display("FAIL rand_gnt cyc %0d got %b exp %b", n, rnd_gnt_o, rwin);
      end
      if (rwin) begin
        qdue.push_back(n + 3);
        qdat.push_back(ref_mem[rnd_adr_i[4:0]]);
      end
      if (hwin) begin
        free_at = n + 4;
        ack_due = n + 3;
        if (hwe) ref_mem[hw] = hdat;
        else exp_rd = ref_mem[hw];
      end

      expv = (qdue.size() > 0) && (qdue[0] == n);
      checks++;
      if (rnd_valid_o !== expv) begin
        errors++;
        $display("FAIL rand_valid cyc %0d got %b exp %b", n, rnd_valid_o, expv);
      end
      if (expv) begin
        checks++;
        if (rnd_dat_o !== qdat[0]) begin
          errors++;
          $display("FAIL rand_rdata cyc %0d got %h exp %h", n, rnd_dat_o, qdat[0]);
        end
        void'(qdue.pop_front());
        void'(qdat.pop_front());
      end

      checks++;
      if (ack_o !== (n == ack_due)) begin
        errors++;
        $display("FAIL rand_ack cyc %0d got %b exp %b", n, ack_o, n == ack_due);
      end
      if (n == ack_due) begin
        if (!hwe) begin
          checks++;
          if (dat_o !== exp_rd) begin
            errors++;
            $display("FAIL rand_hdata cyc %0d got %h exp %h", n, dat_o, exp_rd);
          end
        end
        hact = 0;
      end
      tick();
    end

    checks++;
    if (qdue.size() != 0 || hact) begin
      errors++;
      $display("FAIL rand_drain got pending_rnd=%0d host_active=%0d exp 0 0", qdue.size(), hact);
    end
    cyc_i = 1'b0;
    stb_i = 1'b0;
    rnd_req_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish before 200000ns");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    test_reset();
    test_render_burst();
    test_host_write();
    test_starvation();
    test_stb_hold();
    test_reset_mid();
    test_cyc_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
